// File: rtl/raster_edge_setup.sv
// raster_edge_setup: triangle edge-function setup (a, b, c per edge plus 2x area) built around
// one time-shared pipelined multiplier. Define RASTER_CULL_EN to drop clockwise/degenerate triangles.
module raster_edge_setup #(
    parameter int DATA_BITS   = 32,
    parameter int MUL_LATENCY = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              valid_in,
    output logic                              ready_in,
    input  logic [2:0][1:0][DATA_BITS-1:0]    vertices,
    output logic                              valid_out,
    input  logic                              ready_out,
    output logic [2:0][2:0][DATA_BITS-1:0]    edges,
    output logic [DATA_BITS+1:0]              area,
    output logic                              culled
);
    localparam int W  = DATA_BITS;
    localparam int PW = 2 * DATA_BITS;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        SUM,
        OUT
    } state_t;

    state_t                          state_q;
    logic                            readyIn_q;
    logic                            validOut_q;
    logic [2:0]                      issueCnt_q;
    logic [2:0][1:0][W-1:0]          vtx_q;
    logic [2:0][2:0][W-1:0]          edges_q;
    logic [W+1:0]                    area_q;
    logic signed [PW-1:0]            partial_q;

    logic [MUL_LATENCY-1:0]          mulValid_q;
    logic [MUL_LATENCY-1:0][2:0]     mulTag_q;
    logic [MUL_LATENCY-1:0][PW-1:0]  mulProd_q;

    logic [W-1:0]                    opA_d;
    logic [W-1:0]                    opB_d;
    logic signed [PW-1:0]            opAExt_d;
    logic signed [PW-1:0]            opBExt_d;
    logic signed [PW-1:0]            prod_d;
    logic                            issuing_d;
    logic                            resValid_d;
    logic [2:0]                      resTag_d;
    logic signed [PW-1:0]            resProd_d;
    logic [W-1:0]                    cNew_d;
    logic [W+1:0]                    areaSum_d;

    function automatic logic [W+1:0] sext(input logic [W-1:0] v);
        return {{2{v[W-1]}}, v};
    endfunction

    // Product order pairs up as (even, odd) = (x_j*y_k, x_k*y_j) for edges 0, 1, 2.
    always_comb begin
        opA_d = '0;
        opB_d = '0;
        case (issueCnt_q)
            3'd0: begin opA_d = vtx_q[1][0]; opB_d = vtx_q[2][1]; end
            3'd1: begin opA_d = vtx_q[2][0]; opB_d = vtx_q[1][1]; end
            3'd2: begin opA_d = vtx_q[2][0]; opB_d = vtx_q[0][1]; end
            3'd3: begin opA_d = vtx_q[0][0]; opB_d = vtx_q[2][1]; end
            3'd4: begin opA_d = vtx_q[0][0]; opB_d = vtx_q[1][1]; end
            3'd5: begin opA_d = vtx_q[1][0]; opB_d = vtx_q[0][1]; end
            default: begin opA_d = '0; opB_d = '0; end
        endcase
    end

    assign opAExt_d   = $signed({{W{opA_d[W-1]}}, opA_d});
    assign opBExt_d   = $signed({{W{opB_d[W-1]}}, opB_d});
    assign prod_d     = opAExt_d * opBExt_d;
    assign issuing_d  = (state_q == ISSUE);

    assign resValid_d = mulValid_q[MUL_LATENCY-1];
    assign resTag_d   = mulTag_q[MUL_LATENCY-1];
    assign resProd_d  = $signed(mulProd_q[MUL_LATENCY-1]);
    assign cNew_d     = W'(partial_q - resProd_d);
    assign areaSum_d  = sext(edges_q[0][2]) + sext(edges_q[1][2]) + sext(edges_q[2][2]);

`ifdef RASTER_CULL_EN
    logic         culled_q;
    logic [W+1:0] cullArea_d;

    // Decided while c2 is being written so the pulse lands in the SUM cycle.
    assign cullArea_d = sext(edges_q[0][2]) + sext(edges_q[1][2]) + sext(cNew_d);
    assign culled     = culled_q;
`else
    assign culled     = 1'b0;
`endif

    // Multiplier pipeline; clearing the valid chain on reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            mulValid_q <= '0;
            mulTag_q   <= '0;
            mulProd_q  <= '0;
        end else begin
            mulValid_q <= MUL_LATENCY'({mulValid_q, issuing_d});
            mulTag_q   <= (3 * MUL_LATENCY)'({mulTag_q, issueCnt_q});
            mulProd_q  <= (PW * MUL_LATENCY)'({mulProd_q, prod_d});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            readyIn_q  <= 1'b1;
            validOut_q <= 1'b0;
            issueCnt_q <= '0;
            vtx_q      <= '0;
            edges_q    <= '0;
            area_q     <= '0;
            partial_q  <= '0;
`ifdef RASTER_CULL_EN
            culled_q   <= 1'b0;
`endif
        end else begin
`ifdef RASTER_CULL_EN
            culled_q   <= 1'b0;
`endif
            if (resValid_d) begin
                if (!resTag_d[0]) begin
                    partial_q <= resProd_d;
                end else begin
                    edges_q[resTag_d[2:1]][2] <= cNew_d;
                end
            end

            case (state_q)
                IDLE: begin
                    if (valid_in && readyIn_q) begin
                        vtx_q         <= vertices;
                        edges_q[0][0] <= vertices[1][1] - vertices[2][1];
                        edges_q[0][1] <= vertices[2][0] - vertices[1][0];
                        edges_q[0][2] <= '0;
                        edges_q[1][0] <= vertices[2][1] - vertices[0][1];
                        edges_q[1][1] <= vertices[0][0] - vertices[2][0];
                        edges_q[1][2] <= '0;
                        edges_q[2][0] <= vertices[0][1] - vertices[1][1];
                        edges_q[2][1] <= vertices[1][0] - vertices[0][0];
                        edges_q[2][2] <= '0;
                        readyIn_q     <= 1'b0;
                        state_q       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issueCnt_q == 3'd5) begin
                        issueCnt_q <= '0;
                        state_q    <= DRAIN;
                    end else begin
                        issueCnt_q <= issueCnt_q + 3'd1;
                    end
                end
                DRAIN: begin
                    if (resValid_d && (resTag_d == 3'd5)) begin
`ifdef RASTER_CULL_EN
                        culled_q <= cullArea_d[W+1] || (cullArea_d == '0);
`endif
                        state_q  <= SUM;
                    end
                end
                SUM: begin
                    area_q <= areaSum_d;
`ifdef RASTER_CULL_EN
                    if (culled_q) begin
                        readyIn_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        validOut_q <= 1'b1;
                        state_q    <= OUT;
                    end
`else
                    validOut_q <= 1'b1;
                    state_q    <= OUT;
`endif
                end
                OUT: begin
                    if (ready_out) begin
                        validOut_q <= 1'b0;
                        readyIn_q  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_in  = readyIn_q;
    assign valid_out = validOut_q;
    assign edges     = edges_q;
    assign area      = area_q;

endmodule

// File: tb/tb_raster_edge_setup.sv
// tb_raster_edge_setup: directed vectors with a scoreboard queue; a negedge monitor pops and
// compares every edge set or cull pulse the DUT presents.
module tb_raster_edge_setup;
    localparam int DataBits   = 32;
    localparam int MulLatency = 3;
    localparam int OutLatency = MulLatency + 8;

    typedef struct packed {
        logic [2:0][2:0][31:0] e;
        logic [33:0]           area;
        logic                  cull;
        int                    acceptCyc;
    } expItem_t;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         validIn;
    logic                         readyIn;
    logic [2:0][1:0][31:0]        vIn;
    logic                         validOut;
    logic                         readyOut;
    logic [2:0][2:0][31:0]        dutEdges;
    logic [33:0]                  dutArea;
    logic                         dutCulled;

    expItem_t expQ[$];
    int       checksTotal = 0;
    int       checksPassed = 0;
    int       cycle = 0;
    logic     prevValid = 1'b0;
    logic     prevReadyOut = 1'b0;
    logic     prevDone = 1'b0;
    int       waitedCycles;

    raster_edge_setup #(
        .DATA_BITS  (DataBits),
        .MUL_LATENCY(MulLatency)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_in (validIn),
        .ready_in (readyIn),
        .vertices (vIn),
        .valid_out(validOut),
        .ready_out(readyOut),
        .edges    (dutEdges),
        .area     (dutArea),
        .culled   (dutCulled)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic longint sx(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint sxArea(input logic [33:0] v);
        return longint'($signed(v));
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checksTotal++;
        if (actual == expected) checksPassed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    endtask

    task automatic failCheck(input string name, input string msg);
        checksTotal++;
        $display("[TB] FAIL %s: %s (cycle %0d)", name, msg, cycle);
    endtask

    // Drives one vertex set, waits for acceptance and optionally records its expected result.
    task automatic applyStimulus(input int x0, input int y0, input int x1, input int y1,
                                 input int x2, input int y2,
                                 input int a0, input int b0, input int c0,
                                 input int a1, input int b1, input int c1,
                                 input int a2, input int b2, input int c2,
                                 input longint expArea, input bit keepValid, input bit track);
        expItem_t item;
        bit       accepted = 0;
        int       acc = 0;
        vIn[0][0] = 32'(x0); vIn[0][1] = 32'(y0);
        vIn[1][0] = 32'(x1); vIn[1][1] = 32'(y1);
        vIn[2][0] = 32'(x2); vIn[2][1] = 32'(y2);
        validIn = 1'b1;
        waitedCycles = 0;
        while (!accepted && waitedCycles < 100) begin
            @(negedge clk);
            waitedCycles++;
            if (readyIn && !reset) begin
                accepted = 1;
                acc = cycle;
            end
            @(posedge clk);
            #1;
        end
        if (!keepValid) validIn = 1'b0;
        if (!accepted) begin
            failCheck("acceptTimeout", "vertex set never accepted");
        end else if (track) begin
            item.e[0][0] = 32'(a0); item.e[0][1] = 32'(b0); item.e[0][2] = 32'(c0);
            item.e[1][0] = 32'(a1); item.e[1][1] = 32'(b1); item.e[1][2] = 32'(c1);
            item.e[2][0] = 32'(a2); item.e[2][1] = 32'(b2); item.e[2][2] = 32'(c2);
            item.area = 34'(expArea);
`ifdef RASTER_CULL_EN
            item.cull = (expArea <= 0);
`else
            item.cull = 1'b0;
`endif
            item.acceptCyc = acc;
            expQ.push_back(item);
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (expQ.size() != 0) begin
            failCheck("drainTimeout", "expected output never appeared");
            expQ.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: stability while stalled, latency, contents, and ready_in after each completion.
    always @(negedge clk) begin
        if (reset) begin
            prevValid    = 1'b0;
            prevReadyOut = 1'b0;
            prevDone     = 1'b0;
        end else begin
            if (prevDone) checkOutput("readyInAfterDone", longint'(readyIn), 1);
            if (prevValid && !prevReadyOut) checkOutput("validOutHeld", longint'(validOut), 1);
            if (validOut || dutCulled) begin
                if (expQ.size() == 0) begin
                    if (!prevValid || dutCulled) failCheck("unexpectedOutput", "output with empty scoreboard");
                end else if (dutCulled) begin
                    checkOutput("culledExpected", longint'(dutCulled), longint'(expQ[0].cull));
                    checkOutput("culledLatency", longint'(cycle - expQ[0].acceptCyc), OutLatency - 1);
                    void'(expQ.pop_front());
                end else begin
                    checkOutput("validNotCulled", longint'(validOut), longint'(!expQ[0].cull));
                    if (!prevValid)
                        checkOutput("outLatency", longint'(cycle - expQ[0].acceptCyc), OutLatency);
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            checkOutput($sformatf("edge%0d.%0d", i, j), sx(dutEdges[i][j]),
                                        sx(expQ[0].e[i][j]));
                    checkOutput("area", sxArea(dutArea), sxArea(expQ[0].area));
                    checkOutput("readyInBusy", longint'(readyIn), 0);
                    if (readyOut) void'(expQ.pop_front());
                end
            end
            prevValid    = validOut;
            prevReadyOut = readyOut;
            prevDone     = (validOut && readyOut) || dutCulled;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        reset    = 1'b1;
        validIn  = 1'b0;
        readyOut = 1'b1;
        vIn      = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rstReadyIn", longint'(readyIn), 1);
        checkOutput("rstValidOut", longint'(validOut), 0);
        checkOutput("rstCulled", longint'(dutCulled), 0);
        checkOutput("rstArea", sxArea(dutArea), 0);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                checkOutput($sformatf("rstEdge%0d.%0d", i, j), sx(dutEdges[i][j]), 0);
        @(posedge clk);
        #1;

        $display("[TB] CCW right triangle");
        applyStimulus(0, 0, 4, 0, 0, 4, -4, -4, 16, 4, 0, 0, 0, 4, 0, 16, 0, 1);
        waitDrain();

        $display("[TB] same triangle with 20-cycle output stall");
        readyOut = 1'b0;
        applyStimulus(0, 0, 4, 0, 0, 4, -4, -4, 16, 4, 0, 0, 0, 4, 0, 16, 0, 1);
        n = 0;
        while (!validOut && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!validOut) failCheck("stallValidTimeout", "valid_out never rose");
        repeat (20) @(posedge clk);
        #1 readyOut = 1'b1;
        waitDrain();

        $display("[TB] clockwise, collinear and truncating triangles");
        applyStimulus(0, 0, 0, 4, 4, 0, 4, 4, -16, 0, -4, 0, -4, 0, 0, -16, 0, 1);
        waitDrain();
        applyStimulus(1, 1, 2, 2, 3, 3, -1, 1, 0, 2, -2, 0, -1, 1, 0, 0, 0, 1);
        waitDrain();
        applyStimulus(0, 0, 65536, 0, 0, 65536, -65536, -65536, 0, 65536, 0, 0, 0, 65536, 0, 0, 0, 1);
        waitDrain();

        $display("[TB] mixed-sign and large coordinates");
        applyStimulus(5, -3, 1, 9, -7, 2, 7, -8, 65, 5, 12, 11, -12, -4, 48, 124, 0, 1);
        waitDrain();
        applyStimulus(-1000, -1000, 1000, -1000, 0, 1000, -2000, -1000, 1000000,
                      2000, -1000, 1000000, 0, 2000, 2000000, 4000000, 0, 1);
        waitDrain();

        $display("[TB] reset during ISSUE");
        applyStimulus(-1000, -1000, 1000, -1000, 0, 1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("abortReadyIn", longint'(readyIn), 1);
        checkOutput("abortValidOut", longint'(validOut), 0);
        checkOutput("abortArea", sxArea(dutArea), 0);
        checkOutput("abortEdge0a", sx(dutEdges[0][0]), 0);
        repeat (20) @(posedge clk);
        #1;
        applyStimulus(5, -3, 1, 9, -7, 2, 7, -8, 65, 5, 12, 11, -12, -4, 48, 124, 0, 1);
        waitDrain();

        $display("[TB] back-to-back valid_in");
        applyStimulus(0, 0, 4, 0, 0, 4, -4, -4, 16, 4, 0, 0, 0, 4, 0, 16, 1, 1);
        applyStimulus(-1000, -1000, 1000, -1000, 0, 1000, -2000, -1000, 1000000,
                      2000, -1000, 1000000, 0, 2000, 2000000, 4000000, 1, 1);
        checkOutput("backToBackWait", longint'(waitedCycles), MulLatency + 9);
        validIn = 1'b0;
        waitDrain();

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end
endmodule

// File: doc/raster_edge_setup.md
Name: raster_edge_setup

Overview:
- Triangle edge-setup stage. Takes three screen-space vertices and produces the three edge-function coefficient triples (a, b, c) that the raster edge evaluator consumes, plus twice the signed triangle area.
- Sits between the primitive fetch/assembly stage and the raster tile/edge evaluators.
- Uses one shared pipelined signed multiplier, time-multiplexed under an FSM. Valid/ready handshakes on both sides.

Parameters:
- DATA_BITS, 32, signed width of coordinates and of every edge coefficient.
- MUL_LATENCY, 3, pipeline depth of the shared multiplier; must be >= 1.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- valid_in  input  1  vertex set valid
- ready_in  output  1  block can accept a vertex set
- vertices  input  [2:0][1:0][DATA_BITS]  vertex i: [0]=x, [1]=y, signed
- valid_out  output  1  edge set valid
- ready_out  input  1  downstream accepts edge set
- edges  output  [2:0][2:0][DATA_BITS]  edge i: [0]=a, [1]=b, [2]=c, signed
- area  output  DATA_BITS+2  2x signed area, equal to c0+c1+c2, sign-extended sum
- culled  output  1  one-cycle pulse when a primitive is dropped

Behaviour:
- Edge i runs from v_j to v_k, with j=(i+1)%3 and k=(i+2)%3.
  - a_i = y_j - y_k
  - b_i = x_k - x_j
  - c_i = x_j*y_k - x_k*y_j
- Arithmetic is two's complement. a and b are truncated to DATA_BITS. Products are full 2*DATA_BITS. Each c is truncated to DATA_BITS after subtraction.
- With this convention a counter-clockwise triangle gives positive area, and E_i(v_i) = area for every i.
- FSM states: IDLE, ISSUE, DRAIN, SUM, OUT.
  - IDLE: ready_in=1. On valid_in&&ready_in (cycle T0), register vertices, compute a/b for all edges, go to ISSUE.
  - ISSUE: 6 cycles, T0+1..T0+6. Issue products in order x1*y2, x2*y1, x2*y0, x0*y2, x0*y1, x1*y0. A 3-bit issue counter wraps to 0 on exit.
  - DRAIN: wait until the last product returns at T0+6+MUL_LATENCY. Even-index products load a partial; odd-index products subtract from it, writing c_0, c_1, c_2 in turn.
  - SUM: one cycle; register area = sign-extended c0+c1+c2.
  - OUT: valid_out=1, first seen in cycle T0+MUL_LATENCY+8 (11 with the default). edges/area are held stable until ready_out. On valid_out&&ready_out, go to IDLE.
- Handshake rules:
  - ready_in=0 in every state except IDLE. No input overlap; throughput is one primitive per MUL_LATENCY+9 cycles minimum.
  - valid_out, once asserted, is never deasserted without ready_out. Outputs are unchanged while stalled.
  - valid_in while busy is ignored; upstream must hold it.
- Reset (any state, including mid-ISSUE/DRAIN):
  - FSM returns to IDLE next cycle.
  - valid_out=0, culled=0, ready_in=1 after reset.
  - edges=0, area=0, issue counter=0.
  - In-flight multiplier results are discarded via a reset-cleared in-flight valid shift chain of MUL_LATENCY stages.
- Degenerate triangles (area==0) pass through unchanged when culling is compiled out.
- culled is held 0 when RASTER_CULL_EN is undefined.

Optional Feature:
- Macro: RASTER_CULL_EN.
- Defined: at the end of SUM, if area <= 0 (clockwise or degenerate), skip OUT. culled pulses for one cycle and the FSM returns to IDLE, so ready_in=1 the following cycle. No valid_out is produced.
- Undefined: every primitive reaches OUT; culled tied to 0.

Test Plan:
- v0=(0,0), v1=(4,0), v2=(0,4), ready_out=1 -> valid_out at T0+11.
  - edges: e0=(-4,-4,16), e1=(4,0,0), e2=(0,4,0); area=16.
- Same triangle, ready_out held 0 for 20 cycles -> valid_out stays 1 and edges/area are constant; ready_in=0 throughout. Handshake completes on the first ready_out, and ready_in=1 the next cycle.
- Clockwise v0=(0,0), v1=(0,4), v2=(4,0):
  - Without RASTER_CULL_EN -> area=-16, e0=(4,4,-16).
  - With RASTER_CULL_EN -> no valid_out, culled pulses once at T0+10.
- Collinear v0=(1,1), v1=(2,2), v2=(3,3) -> area=0. Passes through without culling; culled when RASTER_CULL_EN is defined.
- Reset asserted at T0+4 (mid-ISSUE) -> no valid_out ever for that primitive. A new primitive accepted after reset produces correct results with no stale product mixing.
- Negative/large coordinates, DATA_BITS=32:
  - v0=(-1000,-1000), v1=(1000,-1000), v2=(0,1000) -> e0=(-2000,-1000,1000000), area=4000000.
  - valid_in held high back-to-back -> the second primitive is accepted only in IDLE.
